freq_gate_ctrl: RTL and testbench

//   Sequencer for the frequency-meter pulse counter. Drives the counter's enable as a precise gate window
//   (1 s / 100 ms / 10 ms / 1 ms), waits out the counter's output pipeline, then latches the count with a
//   one-cycle valid strobe. Supports single-shot and continuous modes. Sits between the counter and display/UART.

---
 rtl/freq_gate_ctrl_pkg.sv | 25 ++
 rtl/freq_gate_ctrl_if.sv | 35 +++
 rtl/freq_gate_ctrl_gate_timer.sv | 25 ++
 rtl/freq_gate_ctrl.sv | 143 ++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/freq_gate_ctrl_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer:
// FSM state encoding, gate_sel encodings and the gate-length divisor table.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_1S    = 2'd0;
  localparam logic [1:0] SEL_100MS = 2'd1;
  localparam logic [1:0] SEL_10MS  = 2'd2;
  localparam logic [1:0] SEL_1MS   = 2'd3;

  localparam int DEF_CNT_W = 28;

  localparam int unsigned GATE_DIV [4] = '{1, 10, 100, 1000};

  // Gate window length in clock cycles for a given range selection.
  function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] sel);
    return clk_hz / GATE_DIV[sel];
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/result bundle between the gate sequencer, the pulse counter and the consumer.
// The ovf signal exists only when FREQ_GATE_OVF_EN is defined.
interface freq_gate_ctrl_if #(
  parameter int CNT_W = 28
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] count_in;
  logic             gate_en;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic [1:0]       result_range;
  logic             result_valid;
`ifdef FREQ_GATE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, continuous, abort, gate_sel, count_in,
`ifdef FREQ_GATE_OVF_EN
    input  ovf,
`endif
    input  gate_en, busy, result, result_range, result_valid
  );

  modport slave (
    input  start, continuous, abort, gate_sel, count_in,
`ifdef FREQ_GATE_OVF_EN
    output ovf,
`endif
    output gate_en, busy, result, result_range, result_valid
  );
endinterface

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter with a zero flag; times both the gate window and the capture delay.
module gate_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer for the frequency meter: opens the counter enable for a precise window,
// waits out the counter pipeline, then latches the count. FREQ_GATE_OVF_EN adds overflow detection.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int          CNT_W       = DEF_CNT_W,
  parameter int          CAPTURE_DLY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  freq_gate_ctrl_if.slave bus
);
  localparam int TMR_W = $clog2(CLK_HZ + 1);

  state_t           state_reg, state_next;
  logic [1:0]       sel_q_reg, sel_q_next;
  logic             gate_en_reg, gate_en_next;
  logic             busy_reg;
  logic [CNT_W-1:0] result_reg, result_next;
  logic [1:0]       range_reg, range_next;
  logic             valid_reg, valid_next;
`ifdef FREQ_GATE_OVF_EN
  logic             ovf_reg, ovf_next;
`endif

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  function automatic logic [TMR_W-1:0] win_load(input logic [1:0] sel);
    return TMR_W'(gate_len(CLK_HZ, sel) - 1);
  endfunction

  gate_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state_reg;
    sel_q_next   = sel_q_reg;
    gate_en_next = 1'b0;
    result_next  = result_reg;
    range_next   = range_reg;
    valid_next   = 1'b0;
`ifdef FREQ_GATE_OVF_EN
    ovf_next     = ovf_reg;
`endif
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_dec      = 1'b0;

    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sel_q_next   = bus.gate_sel;
            tmr_load     = 1'b1;
            tmr_val      = win_load(bus.gate_sel);
            gate_en_next = 1'b1;
            state_next   = GATE;
          end
        end
        GATE: begin
          if (tmr_zero) begin
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(CAPTURE_DLY - 1);
            state_next = CAPTURE;
          end else begin
            tmr_dec      = 1'b1;
            gate_en_next = 1'b1;
          end
        end
        CAPTURE: begin
          if (tmr_zero) begin
            range_next = sel_q_reg;
            valid_next = 1'b1;
`ifdef FREQ_GATE_OVF_EN
            ovf_next    = &bus.count_in;
            result_next = (&bus.count_in) ? {CNT_W{1'b1}} : bus.count_in;
`else
            result_next = bus.count_in;
`endif
            // Back-to-back windows: the capture delay already kept the counter disabled.
            if (bus.continuous) begin
              sel_q_next   = bus.gate_sel;
              tmr_load     = 1'b1;
              tmr_val      = win_load(bus.gate_sel);
              gate_en_next = 1'b1;
              state_next   = GATE;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sel_q_reg   <= '0;
      gate_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
      result_reg  <= '0;
      range_reg   <= '0;
      valid_reg   <= 1'b0;
`ifdef FREQ_GATE_OVF_EN
      ovf_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      sel_q_reg   <= sel_q_next;
      gate_en_reg <= gate_en_next;
      busy_reg    <= (state_next != IDLE);
      result_reg  <= result_next;
      range_reg   <= range_next;
      valid_reg   <= valid_next;
`ifdef FREQ_GATE_OVF_EN
      ovf_reg     <= ovf_next;
`endif
    end
  end

  assign bus.gate_en      = gate_en_reg;
  assign bus.busy         = busy_reg;
  assign bus.result       = result_reg;
  assign bus.result_range = range_reg;
  assign bus.result_valid = valid_reg;
`ifdef FREQ_GATE_OVF_EN
  assign bus.ovf          = ovf_reg;
`endif
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl at CLK_HZ=1000 with a behavioural pulse counter
// (input period 10 clk, enable->count latency 2). Honours FREQ_GATE_OVF_EN.
module tb_freq_gate_ctrl;
  import freq_meter_pkg::*;

  localparam int unsigned CLK_HZ = 1000;
  localparam int CNT_W = 28;
  localparam int DLY   = 2;

  typedef struct {
    logic [CNT_W-1:0] res;
    logic [1:0]       rng;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_gate_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  freq_gate_ctrl #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .CAPTURE_DLY(DLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Behavioural pulse counter: phase aligned to the window opening, cleared while disabled,
  // one output register so count_in lags the enable by two edges.
  int               ph = 0;
  logic [CNT_W-1:0] raw = '0;
  logic [CNT_W-1:0] pipe = '0;
  logic             force_max = 1'b0;

  always @(posedge clk) begin
    if (!bus_if.gate_en) begin
      ph  <= 0;
      raw <= '0;
    end else begin
      ph <= (ph == 9) ? 0 : ph + 1;
      if (ph == 9) raw <= raw + 1'b1;
    end
    pipe <= raw;
  end

  assign bus_if.count_in = force_max ? {CNT_W{1'b1}} : pipe;

  // Monitor: every result_valid strobe pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus_if.result_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", longint'(bus_if.result), longint'(e.res));
        check("sb_range", longint'(bus_if.result_range), longint'(e.rng));
`ifdef FREQ_GATE_OVF_EN
        check("sb_ovf", longint'(bus_if.ovf), longint'(e.ovf));
`endif
      end
    end
  end

  task automatic push(input logic [CNT_W-1:0] r, input logic [1:0] g, input logic o);
    exp_t e;
    e.res = r; e.rng = g; e.ovf = o;
    sb_q.push_back(e);
  endtask

  // One single-shot window; checks gate width, strobe position/width and busy release.
  task automatic run_single(input logic [1:0] sel, input logic [CNT_W-1:0] exp_res, input logic exp_ovf);
    int n, hi, vcnt, vidx;
    n = int'(CLK_HZ / GATE_DIV[sel]);
    hi = 0; vcnt = 0; vidx = 0;
    push(exp_res, sel, exp_ovf);
    @(negedge clk);
    bus_if.gate_sel = sel;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 1; i <= n + DLY + 10; i++) begin
      if (bus_if.gate_en) hi++;
      if (bus_if.result_valid) begin vcnt++; vidx = i; end
      @(negedge clk);
    end
    check($sformatf("gate_width_sel%0d", sel), hi, n);
    check($sformatf("valid_count_sel%0d", sel), vcnt, 1);
    check($sformatf("valid_pos_sel%0d", sel), vidx, n + DLY + 1);
    check($sformatf("busy_done_sel%0d", sel), longint'(bus_if.busy), 0);
  endtask

  initial begin
    int vidx[$];
    int hi, bsy, nv;
    bus_if.start = 1'b0;
    bus_if.continuous = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.gate_sel = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_gate_en", longint'(bus_if.gate_en), 0);
    check("rst_busy", longint'(bus_if.busy), 0);
    check("rst_result", longint'(bus_if.result), 0);
    check("rst_valid", longint'(bus_if.result_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_single(SEL_1S, 28'd100, 1'b0);
    run_single(SEL_100MS, 28'd10, 1'b0);
    run_single(SEL_10MS, 28'd1, 1'b0);
    run_single(SEL_1MS, 28'd0, 1'b0);

    // Continuous: continuous is dropped after the third strobe, so the fourth window still reports.
    for (int k = 0; k < 4; k++) push(28'd1, SEL_10MS, 1'b0);
    hi = 0; bsy = 0; nv = 0;
    @(negedge clk);
    bus_if.gate_sel = SEL_10MS;
    bus_if.continuous = 1'b1;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (bus_if.gate_en) hi++;
      if (bus_if.busy) bsy++;
      if (bus_if.result_valid) begin
        vidx.push_back(i);
        nv++;
        if (nv == 3) bus_if.continuous = 1'b0;
      end
      @(negedge clk);
    end
    check("cont_valid_count", nv, 4);
    for (int k = 1; k < vidx.size(); k++)
      check($sformatf("cont_period_%0d", k), vidx[k] - vidx[k-1], 12);
    check("cont_gate_low_cycles", bsy - hi, 4 * DLY);
    check("cont_busy_done", longint'(bus_if.busy), 0);

    // Abort at cycle 500 of a 1 s window; previous result must survive.
    bus_if.gate_sel = SEL_1S;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (499) @(negedge clk);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort_gate_en", longint'(bus_if.gate_en), 0);
    check("abort_busy", longint'(bus_if.busy), 0);
    nv = 0;
    for (int i = 0; i < 1100; i++) begin
      if (bus_if.result_valid) nv++;
      @(negedge clk);
    end
    check("abort_no_valid", nv, 0);
    check("abort_result_held", longint'(bus_if.result), 1);
    check("abort_range_held", longint'(bus_if.result_range), 2);

    // abort dominates a simultaneous start in IDLE
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    check("abort_over_start_busy", longint'(bus_if.busy), 0);

    // Reset at cycle 300 of a window
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_gate_en", longint'(bus_if.gate_en), 0);
    check("midrst_busy", longint'(bus_if.busy), 0);
    check("midrst_result", longint'(bus_if.result), 0);
    check("midrst_range", longint'(bus_if.result_range), 0);
    check("midrst_valid", longint'(bus_if.result_valid), 0);
    run_single(SEL_100MS, 28'd10, 1'b0);

`ifdef FREQ_GATE_OVF_EN
    force_max = 1'b1;
    run_single(SEL_1MS, {CNT_W{1'b1}}, 1'b1);
    force_max = 1'b0;
    run_single(SEL_10MS, 28'd1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
